wb_regfile_reader: RTL and testbench

- Receiving end of the writeback interface: a 32-entry integer register file with one write port and two read ports.
- The write port is driven by the writeback stage: RegWriteW, RdW, ResultW.
- The two read ports serve decode, with same-cycle write-to-read bypass.
- Read results and source/destination indices are captured into the D→E pipeline register, with stall and flush control.

---
 rtl/wb_regfile_reader_pkg.sv | 23 ++
 rtl/wb_regfile_reader_regfile_core.sv | 81 ++++++++
 rtl/wb_regfile_reader.sv | 89 ++++++++
 tb/tb_wb_regfile_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_reader_pkg.sv
// Shared pipeline definitions for the writeback-side register file and the
// decode-to-execute capture register.
package wb_regfile_reader_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   // Architectural x0: hardwired to zero, never written.
   localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

   // Control half of the E-stage register (the data half is XLEN-parameterised
   // in the top level).
   typedef struct packed {
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rs2;
      logic [REG_IDX_W-1:0] rd;
      logic                 valid;
   } e_ctrl_t;

   // Bubble inserted on flush and loaded on reset: all fields 0, not valid.
   localparam e_ctrl_t E_CTRL_BUBBLE = '{rs1: '0, rs2: '0, rd: '0, valid: 1'b0};

endpackage : wb_regfile_reader_pkg

// File: rtl/wb_regfile_reader_regfile_core.sv
// Register file storage: one write port, two combinational read ports,
// x0 masking and optional same-cycle write-to-read bypass.
module regfile_core
   import wb_regfile_reader_pkg::*;
#(
   parameter int XLEN      = wb_regfile_reader_pkg::XLEN,
   parameter int NREG      = 32,
   parameter int BYPASS_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] waddr,
   input  logic [XLEN-1:0]      wdata,
   input  logic [REG_IDX_W-1:0] raddr1,
   input  logic [REG_IDX_W-1:0] raddr2,
   output logic [XLEN-1:0]      rdata1,
   output logic [XLEN-1:0]      rdata2
);

   // Only the low IDX_W index bits select an entry.
   localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

   // An entry is live when it exists and is not x0.
   function automatic logic idx_live(input logic [IDX_W-1:0] i);
      return (int'(i) < NREG) && (i != ZERO_REG[IDX_W-1:0]);
   endfunction

   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] r1_idx;
   logic [IDX_W-1:0] r2_idx;

   assign w_idx  = waddr[IDX_W-1:0];
   assign r1_idx = raddr1[IDX_W-1:0];
   assign r2_idx = raddr2[IDX_W-1:0];

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];

   // Next storage contents: apply the single write, dropping x0 and
   // out-of-range destinations.
   always_comb begin
      // NOTE: default the whole array first so every path assigns it (no latch).
      regs_d = regs_q;
      if (we && idx_live(w_idx)) begin
         regs_d[w_idx] = wdata;
      end
   end

   // Storage register; reset clears every entry asynchronously, so a write
   // pending when rst_n falls never lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this array is cleared on reset because software relies on
         // zeroed registers; plain RAM-style storage would normally skip it.
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         // NOTE: state updates use non-blocking assignments so all flops
         // sample the same pre-edge values.
         regs_q <= regs_d;
      end
   end

   // Decode reads: x0/out-of-range read 0, a same-cycle write to the same
   // index is forwarded when bypass is enabled, otherwise the stored value.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (idx_live(r1_idx)) begin
         if ((BYPASS_EN != 0) && we && (w_idx == r1_idx)) rdata1 = wdata;
         else                                             rdata1 = regs_q[r1_idx];
      end
      if (idx_live(r2_idx)) begin
         if ((BYPASS_EN != 0) && we && (w_idx == r2_idx)) rdata2 = wdata;
         else                                             rdata2 = regs_q[r2_idx];
      end
   end

endmodule : regfile_core

// File: rtl/wb_regfile_reader.sv
// Writeback-fed register file plus the D->E pipeline capture register with
// flush-over-stall priority.
module wb_regfile_reader
   import wb_regfile_reader_pkg::*;
#(
   parameter int XLEN      = wb_regfile_reader_pkg::XLEN,
   parameter int NREG      = 32,
   parameter int BYPASS_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RegWriteW,
   input  logic [REG_IDX_W-1:0] RdW,
   input  logic [XLEN-1:0]      ResultW,
   input  logic [REG_IDX_W-1:0] A1D,
   input  logic [REG_IDX_W-1:0] A2D,
   input  logic [REG_IDX_W-1:0] RdD,
   input  logic                 ValidD,
   input  logic                 StallE,
   input  logic                 FlushE,
   output logic [XLEN-1:0]      RD1D,
   output logic [XLEN-1:0]      RD2D,
   output logic [XLEN-1:0]      RD1E,
   output logic [XLEN-1:0]      RD2E,
   output logic [REG_IDX_W-1:0] Rs1E,
   output logic [REG_IDX_W-1:0] Rs2E,
   output logic [REG_IDX_W-1:0] RdE,
   output logic                 ValidE
);

   regfile_core #(
      .XLEN      (XLEN),
      .NREG      (NREG),
      .BYPASS_EN (BYPASS_EN)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (RegWriteW),
      .waddr  (RdW),
      .wdata  (ResultW),
      .raddr1 (A1D),
      .raddr2 (A2D),
      .rdata1 (RD1D),
      .rdata2 (RD2D)
   );

   logic [XLEN-1:0] e_rd1_q, e_rd1_d;
   logic [XLEN-1:0] e_rd2_q, e_rd2_d;
   e_ctrl_t         e_ctrl_q, e_ctrl_d;

   // E-stage next state: flush inserts a bubble, else stall holds, else the
   // decode slot is captured. A stalled entry is not re-read; forwarding in E
   // covers a later writeback to its sources.
   always_comb begin
      e_rd1_d  = e_rd1_q;
      e_rd2_d  = e_rd2_q;
      e_ctrl_d = e_ctrl_q;
      if (FlushE) begin
         e_rd1_d  = '0;
         e_rd2_d  = '0;
         e_ctrl_d = E_CTRL_BUBBLE;
      end else if (!StallE) begin
         e_rd1_d  = RD1D;
         e_rd2_d  = RD2D;
         e_ctrl_d = '{rs1: A1D, rs2: A2D, rd: RdD, valid: ValidD};
      end
   end

   // E-stage register with asynchronous clear to the bubble value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_rd1_q  <= '0;
         e_rd2_q  <= '0;
         e_ctrl_q <= E_CTRL_BUBBLE;
      end else begin
         e_rd1_q  <= e_rd1_d;
         e_rd2_q  <= e_rd2_d;
         e_ctrl_q <= e_ctrl_d;
      end
   end

   assign RD1E   = e_rd1_q;
   assign RD2E   = e_rd2_q;
   assign Rs1E   = e_ctrl_q.rs1;
   assign Rs2E   = e_ctrl_q.rs2;
   assign RdE    = e_ctrl_q.rd;
   assign ValidE = e_ctrl_q.valid;

endmodule : wb_regfile_reader

// File: tb/tb_wb_regfile_reader.sv
// Self-checking bench: directed vector table, async-reset sequence and a
// randomized run against an array-based reference model. Two instances are
// driven in parallel, one with bypass and one without.
module tb_wb_regfile_reader;

   logic        clk;
   logic        rst_n;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic [4:0]  A1D, A2D, RdD;
   logic        ValidD, StallE, FlushE;

   logic [31:0] b_rd1d, b_rd2d, b_rd1e, b_rd2e;
   logic [4:0]  b_rs1e, b_rs2e, b_rde;
   logic        b_ve;
   logic [31:0] n_rd1d, n_rd2d, n_rd1e, n_rd2e;
   logic [4:0]  n_rs1e, n_rs2e, n_rde;
   logic        n_ve;

   int checks   = 0;
   int failures = 0;

   wb_regfile_reader #(.XLEN(32), .NREG(32), .BYPASS_EN(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .A1D(A1D), .A2D(A2D), .RdD(RdD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
      .RD1D(b_rd1d), .RD2D(b_rd2d), .RD1E(b_rd1e), .RD2E(b_rd2e),
      .Rs1E(b_rs1e), .Rs2E(b_rs2e), .RdE(b_rde), .ValidE(b_ve)
   );

   wb_regfile_reader #(.XLEN(32), .NREG(32), .BYPASS_EN(0)) u_nob (
      .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .A1D(A1D), .A2D(A2D), .RdD(RdD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
      .RD1D(n_rd1d), .RD2D(n_rd2d), .RD1E(n_rd1e), .RD2E(n_rd2e),
      .Rs1E(n_rs1e), .Rs2E(n_rs2e), .RdE(n_rde), .ValidE(n_ve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] rdw, input logic [31:0] res,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rdd,
                        input logic v, input logic st, input logic fl);
      RegWriteW = we; RdW = rdw; ResultW = res;
      A1D = a1; A2D = a2; RdD = rdd; ValidD = v; StallE = st; FlushE = fl;
   endtask

   // Directed vector: inputs for one cycle, expected combinational reads in
   // that cycle, expected bypass-instance E outputs after the edge.
   typedef struct {
      logic        we;
      logic [4:0]  rdw;
      logic [31:0] res;
      logic [4:0]  a1, a2, rdd;
      logic        v, st, fl;
      logic [31:0] x_rd1d, x_rd2d, x_nb_rd1d;
      logic [31:0] x_rd1e;
      logic [4:0]  x_rs1e;
      logic        x_ve;
   } vec_t;

   vec_t tbl [11];

   // Reference model state
   logic [31:0] m_regs [32];
   typedef struct {
      logic [31:0] rd1, rd2;
      logic [4:0]  rs1, rs2, rd;
      logic        v;
   } m_e_t;
   m_e_t m_eb, m_en;

   function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && RegWriteW && RdW == a) return ResultW;
      return m_regs[a];
   endfunction

   function automatic m_e_t m_next(input m_e_t cur, input logic [31:0] r1, input logic [31:0] r2);
      m_e_t n;
      n = cur;
      if (FlushE) n = '{rd1: 0, rd2: 0, rs1: 0, rs2: 0, rd: 0, v: 0};
      else if (!StallE) n = '{rd1: r1, rd2: r2, rs1: A1D, rs2: A2D, rd: RdD, v: ValidD};
      return n;
   endfunction

   initial begin
      tbl[0]  = '{1, 3,  32'hDEADBEEF, 5,  31, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        5,  0};
      tbl[1]  = '{0, 0,  32'h0,        3,  0,  9, 1, 0, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 3,  1};
      tbl[2]  = '{1, 7,  32'h12345678, 7,  7,  1, 1, 0, 0, 32'h12345678, 32'h12345678, 32'h0,        32'h12345678, 7,  1};
      tbl[3]  = '{1, 0,  32'hFFFFFFFF, 0,  7,  2, 1, 0, 0, 32'h0,        32'h12345678, 32'h0,        32'h0,        0,  1};
      tbl[4]  = '{0, 0,  32'h0,        0,  0,  2, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0,  1};
      tbl[5]  = '{1, 10, 32'hA5A5A5A5, 10, 3,  4, 1, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0,        32'hA5A5A5A5, 10, 1};
      tbl[6]  = '{1, 10, 32'h11111111, 3,  7,  8, 0, 1, 0, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'hA5A5A5A5, 10, 1};
      tbl[7]  = '{0, 0,  32'h0,        10, 0,  8, 0, 1, 0, 32'h11111111, 32'h0,        32'h11111111, 32'hA5A5A5A5, 10, 1};
      tbl[8]  = '{0, 0,  32'h0,        1,  2,  8, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'hA5A5A5A5, 10, 1};
      tbl[9]  = '{0, 0,  32'h0,        3,  3,  8, 1, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0,  0};
      tbl[10] = '{0, 0,  32'h0,        31, 10, 4, 1, 0, 0, 32'h0,        32'h11111111, 32'h0,        32'h0,        31, 1};

      // ---------------- reset ----------------
      rst_n = 1'b0;
      drive(0, 0, 0, 5, 31, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset RD1D(x5)",  b_rd1d, 32'h0);
      check("reset RD2D(x31)", b_rd2d, 32'h0);
      check("reset RD1E", b_rd1e, 32'h0);
      check("reset RD2E", b_rd2e, 32'h0);
      check("reset Rs1E", {27'd0, b_rs1e}, 32'h0);
      check("reset Rs2E", {27'd0, b_rs2e}, 32'h0);
      check("reset RdE",  {27'd0, b_rde},  32'h0);
      check("reset ValidE", {31'd0, b_ve}, 32'h0);

      // ---------------- directed table ----------------
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(tbl[i].we, tbl[i].rdw, tbl[i].res, tbl[i].a1, tbl[i].a2, tbl[i].rdd,
               tbl[i].v, tbl[i].st, tbl[i].fl);
         #1;
         check($sformatf("vec%0d RD1D", i), b_rd1d, tbl[i].x_rd1d);
         check($sformatf("vec%0d RD2D", i), b_rd2d, tbl[i].x_rd2d);
         check($sformatf("vec%0d nobyp RD1D", i), n_rd1d, tbl[i].x_nb_rd1d);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d RD1E", i), b_rd1e, tbl[i].x_rd1e);
         check($sformatf("vec%0d Rs1E", i), {27'd0, b_rs1e}, {27'd0, tbl[i].x_rs1e});
         check($sformatf("vec%0d ValidE", i), {31'd0, b_ve}, {31'd0, tbl[i].x_ve});
      end

      // ---------------- async reset mid-operation ----------------
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         drive(1, 5'(k), 32'(k), 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      drive(1, 5, 32'h55, 1, 2, 6, 1, 0, 0);
      @(posedge clk);
      #1;
      check("pre-reset RD1E", b_rd1e, 32'h1);
      check("pre-reset RD2E", b_rd2e, 32'h2);
      #1;
      drive(1, 6, 32'h66, 1, 2, 6, 1, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("async rst RD1E", b_rd1e, 32'h0);
      check("async rst RD2E", b_rd2e, 32'h0);
      check("async rst Rs1E", {27'd0, b_rs1e}, 32'h0);
      check("async rst RdE",  {27'd0, b_rde},  32'h0);
      check("async rst ValidE", {31'd0, b_ve}, 32'h0);
      check("async rst nobyp ValidE", {31'd0, n_ve}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         A1D = 5'(k);
         A2D = 5'(k);
         #1;
         check($sformatf("post-rst x%0d RD1D", k), b_rd1d, 32'h0);
         check($sformatf("post-rst x%0d nobyp RD2D", k), n_rd2d, 32'h0);
      end

      // ---------------- randomized vs model ----------------
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_eb = '{rd1: 0, rd2: 0, rs1: 0, rs2: 0, rd: 0, v: 0};
      m_en = m_eb;
      // Sync model E with the DUT (it captured the last read cycle).
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      for (int c = 0; c < 400; c++) begin
         logic [31:0] eb1, eb2, en1, en2;
         @(negedge clk);
         drive($urandom_range(0, 3) != 0,
               ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
               $urandom,
               ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
               5'($urandom), 1'($urandom),
               $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
         #1;
         eb1 = m_read(A1D, 1); eb2 = m_read(A2D, 1);
         en1 = m_read(A1D, 0); en2 = m_read(A2D, 0);
         check("rnd RD1D", b_rd1d, eb1);
         check("rnd RD2D", b_rd2d, eb2);
         check("rnd nobyp RD1D", n_rd1d, en1);
         check("rnd nobyp RD2D", n_rd2d, en2);
         m_eb = m_next(m_eb, eb1, eb2);
         m_en = m_next(m_en, en1, en2);
         if (RegWriteW && RdW != 5'd0) m_regs[RdW] = ResultW;
         @(posedge clk);
         #1;
         check("rnd RD1E", b_rd1e, m_eb.rd1);
         check("rnd RD2E", b_rd2e, m_eb.rd2);
         check("rnd Rs1E", {27'd0, b_rs1e}, {27'd0, m_eb.rs1});
         check("rnd Rs2E", {27'd0, b_rs2e}, {27'd0, m_eb.rs2});
         check("rnd RdE",  {27'd0, b_rde},  {27'd0, m_eb.rd});
         check("rnd ValidE", {31'd0, b_ve}, {31'd0, m_eb.v});
         check("rnd nobyp RD1E", n_rd1e, m_en.rd1);
         check("rnd nobyp RD2E", n_rd2e, m_en.rd2);
         check("rnd nobyp ValidE", {31'd0, n_ve}, {31'd0, m_en.v});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_wb_regfile_reader
